// File: rtl/cdc_stream_arbiter_if.sv
// Stream bundle for cdc_stream_arbiter: NumIn requester channels in, one
// tagged channel out toward the CDC source port.
//   slave  : the arbiter's view (consumes requests, drives the output beat)
//   master : the environment's view (drives requests, accepts the output beat)
interface cdc_stream_arbiter_if #(
    parameter int NumIn     = 4,
    parameter int DataWidth = 32
);
    localparam int IdxWidth = (NumIn > 1) ? $clog2(NumIn) : 1;

    logic [NumIn*DataWidth-1:0] inp_data_i;
    logic [NumIn-1:0]           inp_valid_i;
    logic [NumIn-1:0]           inp_ready_o;
    logic [DataWidth-1:0]       oup_data_o;
    logic [IdxWidth-1:0]        oup_idx_o;
    logic                       oup_valid_o;
    logic                       oup_ready_i;

    modport slave (
        input  inp_data_i, inp_valid_i, oup_ready_i,
        output inp_ready_o, oup_data_o, oup_idx_o, oup_valid_o
    );

    modport master (
        output inp_data_i, inp_valid_i, oup_ready_i,
        input  inp_ready_o, oup_data_o, oup_idx_o, oup_valid_o
    );
endinterface

// File: rtl/cdc_stream_arbiter.sv
// Round-robin arbiter sharing one registered valid/ready channel (normally a
// 2-phase CDC source port) between NumIn requesters. The output beat is held
// bit-stable until accepted and carries the index of the granted requester.
// Optional macro CDC_ARB_HIPRIO_EN adds parameter HiPrioIdx: that requester
// wins every load it is valid for, without advancing the round-robin pointer.
module cdc_stream_arbiter #(
    parameter int NumIn     = 4,
    parameter int DataWidth = 32
`ifdef CDC_ARB_HIPRIO_EN
    ,
    parameter int HiPrioIdx = 0
`endif
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    cdc_stream_arbiter_if.slave  bus
);
    localparam int IdxWidth = (NumIn > 1) ? $clog2(NumIn) : 1;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t                state_reg, state_next;
    logic [DataWidth-1:0]  data_reg, data_next;
    logic [IdxWidth-1:0]   idx_reg, idx_next;
    logic [IdxWidth-1:0]   rr_reg, rr_next;

    logic [DataWidth-1:0]  in_data [NumIn];
    logic [NumIn-1:0]      grant;
    logic [IdxWidth-1:0]   winner;
    logic                  prio_hit;
    logic                  found;
    int                    cand;
    logic                  any_valid;
    logic                  load_en;
    logic                  load;

    // Unpack the flat payload bus into one slice per requester.
    genvar gi;
    generate
        for (gi = 0; gi < NumIn; gi++) begin : g_unpack
            assign in_data[gi] = bus.inp_data_i[gi*DataWidth +: DataWidth];
        end
    endgenerate

    assign any_valid = |bus.inp_valid_i;
    // The register can take a new beat when empty or when its beat drains now.
    assign load_en   = (state_reg == EMPTY) || bus.oup_ready_i;
    assign load      = load_en && any_valid;

    // Winner search: first valid requester at or above rr_reg, wrapping modulo NumIn.
    always_comb begin
        winner   = rr_reg;
        prio_hit = 1'b0;
        found    = 1'b0;
        cand     = 0;
        for (int k = 0; k < NumIn; k++) begin
            cand = int'(rr_reg) + k;
            if (cand >= NumIn) begin
                cand = cand - NumIn;
            end
            if (!found && bus.inp_valid_i[cand]) begin
                found  = 1'b1;
                winner = IdxWidth'(cand);
            end
        end
`ifdef CDC_ARB_HIPRIO_EN
        if (bus.inp_valid_i[HiPrioIdx]) begin
            winner   = IdxWidth'(HiPrioIdx);
            prio_hit = 1'b1;
        end
`endif
    end

    // One-hot grant decode of the winner.
    generate
        for (gi = 0; gi < NumIn; gi++) begin : g_grant
            assign grant[gi] = any_valid && (winner == IdxWidth'(gi));
        end
    endgenerate

    // Acknowledge only while running; a held reset must never produce a handshake.
    assign bus.inp_ready_o = grant & {NumIn{load_en && rst_ni}};

    // Output-register state: EMPTY/FULL.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: on any load opportunity the register refills or drains to EMPTY.
    always_comb begin
        state_next = state_reg;
        if (load_en) begin
            state_next = any_valid ? FULL : EMPTY;
        end
    end

    // Datapath next values: capture winner on a load; otherwise hold bit-stable.
    always_comb begin
        data_next = data_reg;
        idx_next  = idx_reg;
        rr_next   = rr_reg;
        if (load) begin
            data_next = in_data[winner];
            idx_next  = winner;
            if (!prio_hit) begin
                rr_next = (int'(winner) == NumIn - 1) ? '0 : winner + IdxWidth'(1);
            end
        end
    end

    // Payload, tag and round-robin pointer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_reg <= '0;
            idx_reg  <= '0;
            rr_reg   <= '0;
        end else begin
            data_reg <= data_next;
            idx_reg  <= idx_next;
            rr_reg   <= rr_next;
        end
    end

    // Outputs come straight from registers so they stay stable toward the CDC.
    always_comb begin
        bus.oup_valid_o = (state_reg == FULL);
        bus.oup_data_o  = data_reg;
        bus.oup_idx_o   = idx_reg;
    end
endmodule

// File: tb/tb_cdc_stream_arbiter.sv
// Directed, table-driven bench for cdc_stream_arbiter (NumIn=4, DataWidth=32).
// With CDC_ARB_HIPRIO_EN defined the DUT gets HiPrioIdx=2 and a matching table.
module tb_cdc_stream_arbiter;
    logic clk;
    logic rst_n;

    cdc_stream_arbiter_if #(.NumIn(4), .DataWidth(32)) bus ();

    cdc_stream_arbiter #(
        .NumIn(4),
        .DataWidth(32)
`ifdef CDC_ARB_HIPRIO_EN
        , .HiPrioIdx(2)
`endif
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rst_n;
        logic [3:0]   vld;
        logic         rdy;
        logic [127:0] data;
        logic         ev;
        logic [1:0]   eidx;
        logic [31:0]  edata;
        logic [3:0]   erdy;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [127:0] DEF  = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    localparam logic [127:0] BEEF = {32'hA3, 32'hDEADBEEF, 32'hA1, 32'hA0};
`ifdef CDC_ARB_HIPRIO_EN
    localparam logic [3:0]  FIRST_RDY  = 4'b0100;
    localparam logic [1:0]  FIRST_IDX  = 2'd2;
    localparam logic [31:0] FIRST_DATA = 32'hA2;
`else
    localparam logic [3:0]  FIRST_RDY  = 4'b0001;
    localparam logic [1:0]  FIRST_IDX  = 2'd0;
    localparam logic [31:0] FIRST_DATA = 32'hA0;
`endif

    task automatic add(input logic rn, input logic [3:0] v, input logic rd,
                       input logic [127:0] d, input logic ev, input logic [1:0] ei,
                       input logic [31:0] ed, input logic [3:0] er);
        vec_t t;
        t.rst_n = rn; t.vld = v; t.rdy = rd; t.data = d;
        t.ev = ev; t.eidx = ei; t.edata = ed; t.erdy = er;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.inp_valid_i = '0;
        bus.inp_data_i  = DEF;
        bus.oup_ready_i = 1'b1;

        // Reset held with all requesters valid.
        add(0, 4'hF, 1, DEF, 0, 0, 32'h0, 4'h0);
        add(0, 4'hF, 1, DEF, 0, 0, 32'h0, 4'h0);
`ifdef CDC_ARB_HIPRIO_EN
        // Requester 2 wins while valid; round-robin resumes from untouched pointer.
        add(1, 4'hF, 1, DEF, 0, 0, 32'h0,  4'h4);
        add(1, 4'hF, 1, DEF, 1, 2, 32'hA2, 4'h4);
        add(1, 4'hF, 1, DEF, 1, 2, 32'hA2, 4'h4);
        add(1, 4'hB, 1, DEF, 1, 2, 32'hA2, 4'h1);
        add(1, 4'hB, 1, DEF, 1, 0, 32'hA0, 4'h2);
        add(1, 4'hB, 1, DEF, 1, 1, 32'hA1, 4'h8);
        add(1, 4'hF, 1, DEF, 1, 3, 32'hA3, 4'h4);
        add(1, 4'hB, 1, DEF, 1, 2, 32'hA2, 4'h1);
`else
        // All valid, full throughput: 0,1,2,3,0,1 ...
        add(1, 4'hF, 1, DEF,  0, 0, 32'h0,  4'h1);
        add(1, 4'hF, 1, DEF,  1, 0, 32'hA0, 4'h2);
        add(1, 4'hF, 1, DEF,  1, 1, 32'hA1, 4'h4);
        add(1, 4'hF, 1, DEF,  1, 2, 32'hA2, 4'h8);
        add(1, 4'hF, 1, DEF,  1, 3, 32'hA3, 4'h1);
        add(1, 4'hF, 1, DEF,  1, 0, 32'hA0, 4'h2);
        add(1, 4'hF, 1, BEEF, 1, 1, 32'hA1, 4'h4);
        // Backpressure 10 cycles with toggling requests and changing data.
        for (int k = 0; k < 10; k++) begin
            add(1, 4'(k) ^ 4'hA, 0,
                {32'h5A5A0000 + k, 32'h12340000 + k, 32'hCAFE0000 + k, 32'h0F0F0000 + k},
                1, 2, 32'hDEADBEEF, 4'h0);
        end
        // Release: next grant is 3, then drain to EMPTY with held data.
        add(1, 4'hF, 1, DEF, 1, 2, 32'hDEADBEEF, 4'h8);
        add(1, 4'h0, 1, DEF, 1, 3, 32'hA3, 4'h0);
        add(1, 4'h0, 1, DEF, 0, 3, 32'hA3, 4'h0);
        // Sparse: reach rr=2, then 1 and 3 alternate; requester 0 joins.
        add(1, 4'h2, 1, DEF, 0, 3, 32'hA3, 4'h2);
        add(1, 4'hA, 1, DEF, 1, 1, 32'hA1, 4'h8);
        add(1, 4'hA, 1, DEF, 1, 3, 32'hA3, 4'h2);
        add(1, 4'hA, 1, DEF, 1, 1, 32'hA1, 4'h8);
        add(1, 4'hA, 1, DEF, 1, 3, 32'hA3, 4'h2);
        add(1, 4'hB, 1, DEF, 1, 1, 32'hA1, 4'h8);
        add(1, 4'hB, 1, DEF, 1, 3, 32'hA3, 4'h1);
        add(1, 4'h0, 0, DEF, 1, 0, 32'hA0, 4'h0);
        add(1, 4'h0, 0, DEF, 1, 0, 32'hA0, 4'h0);
`endif

        for (int r = 0; r < vecs.size(); r++) begin
            rst_n           = vecs[r].rst_n;
            bus.inp_valid_i = vecs[r].vld;
            bus.oup_ready_i = vecs[r].rdy;
            bus.inp_data_i  = vecs[r].data;
            @(negedge clk);
            check($sformatf("row%0d valid", r), 32'(bus.oup_valid_o), 32'(vecs[r].ev));
            check($sformatf("row%0d idx", r),   32'(bus.oup_idx_o),   32'(vecs[r].eidx));
            check($sformatf("row%0d data", r),  bus.oup_data_o,       vecs[r].edata);
            check($sformatf("row%0d ready", r), 32'(bus.inp_ready_o), 32'(vecs[r].erdy));
            $display("row %0d: vld=%h rdy=%b -> valid=%b idx=%0d data=%h ready=%b",
                     r, vecs[r].vld, vecs[r].rdy, bus.oup_valid_o, bus.oup_idx_o,
                     bus.oup_data_o, bus.inp_ready_o);
            @(posedge clk);
            #1;
        end

        // Reset while FULL and stalled: valid drops asynchronously, no ready pulse.
        bus.inp_valid_i = 4'hF;
        bus.oup_ready_i = 1'b0;
        bus.inp_data_i  = DEF;
        @(negedge clk);
        check("pre_reset full", 32'(bus.oup_valid_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async reset valid", 32'(bus.oup_valid_o), 32'd0);
        check("async reset data",  bus.oup_data_o,       32'd0);
        check("async reset idx",   32'(bus.oup_idx_o),   32'd0);
        check("async reset ready", 32'(bus.inp_ready_o), 32'd0);
        bus.oup_ready_i = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("held reset ready", 32'(bus.inp_ready_o), 32'd0);
        $display("reset seq: valid=%b ready=%b", bus.oup_valid_o, bus.inp_ready_o);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post reset ready", 32'(bus.inp_ready_o), 32'(FIRST_RDY));
        check("post reset valid", 32'(bus.oup_valid_o), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("first beat valid", 32'(bus.oup_valid_o), 32'd1);
        check("first beat idx",   32'(bus.oup_idx_o),   32'(FIRST_IDX));
        check("first beat data",  bus.oup_data_o,       FIRST_DATA);
        $display("first beat: idx=%0d data=%h", bus.oup_idx_o, bus.oup_data_o);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
